// File: rtl/clock_pkg.sv
// clock_pkg: shared constants for the RTC poll scheduler (FSM encoding, BCD masks, RTC address).
package clock_pkg;
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_COLLECT = 3'd3;
  localparam logic [2:0] S_PUBLISH = 3'd4;
  localparam logic [2:0] S_ERROR   = 3'd5;
  localparam logic [7:0] SEC_MASK  = 8'h7F;
  localparam logic [7:0] MIN_MASK  = 8'h7F;
  localparam logic [7:0] HOUR_MASK = 8'h3F;
  localparam logic [6:0] RTC_DEV_ADDR = 7'h68;
endpackage

// File: rtl/rtc_poll_scheduler_if.sv
// rtc_poll_scheduler_if: command/response handshake between the scheduler and the I2C read core.
interface rtc_poll_scheduler_if;
  logic       rd_address;
  logic       wr_address;
  logic [6:0] data_address;
  logic [7:0] byte_read;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  modport master (output rd_address, wr_address, data_address, byte_read,
                  input in_ready, out_valid, out_data);
  modport slave (input rd_address, wr_address, data_address, byte_read,
                 output in_ready, out_valid, out_data);
endinterface

// File: rtl/poll_timer.sv
// poll_timer: POLL_DIV divider with registered tick and the coalescing pending-request flag.
module poll_timer #(
  parameter int POLL_DIV = 50_000_000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic i_force_req,
  input  logic i_clear,
  output logic o_pending
);
  localparam int W = $clog2(POLL_DIV);
  logic [W-1:0] r_div;
  logic         r_tick;
  logic         w_wrap;
  assign w_wrap = r_div == W'(POLL_DIV - 1);
  // a new request in the issuing cycle wins over the clear so it is not lost
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_div     <= '0;
      r_tick    <= 1'b0;
      o_pending <= 1'b0;
    end else begin
      r_div     <= w_wrap ? '0 : r_div + 1'b1;
      r_tick    <= w_wrap;
      o_pending <= r_tick | i_force_req | (o_pending & ~i_clear);
    end
  end
endmodule

// File: rtl/rtc_poll_scheduler.sv
// rtc_poll_scheduler: polls the RTC over the I2C read core and publishes sec/min/hour atomically.
// Optional watchdog on WAIT_BUSY/COLLECT enabled by defining RTC_POLL_WATCHDOG_EN.
module rtc_poll_scheduler
  import clock_pkg::*;
#(
  parameter int         POLL_DIV  = 50_000_000,
  parameter logic [6:0] DEV_ADDR  = RTC_DEV_ADDR,
  parameter int         NUM_BYTES = 3
`ifdef RTC_POLL_WATCHDOG_EN
  , parameter int       TIMEOUT_CYC = 2_000_000
`endif
) (
  input  logic                 clk_sys,
  input  logic                 reset_n,
  input  logic                 force_req,
  rtc_poll_scheduler_if.master i2c,
  output logic [7:0]           sec_bcd,
  output logic [7:0]           min_bcd,
  output logic [7:0]           hour_bcd,
  output logic                 time_valid,
  output logic                 err,
  output logic                 busy
);
  logic [2:0] r_state, w_fsm, w_nxt;
  logic [3:0] r_cnt, w_cnt;
  logic [7:0] r_shadow [3];
  logic [7:0] w_sh [3];
  logic       r_rd, w_pending, w_byte, w_wr, w_to;
  assign i2c.rd_address   = r_rd;
  assign i2c.wr_address   = 1'b0;
  assign i2c.data_address = DEV_ADDR;
  assign i2c.byte_read    = 8'(NUM_BYTES);
  poll_timer #(.POLL_DIV(POLL_DIV)) u_timer (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .i_force_req (force_req),
    .i_clear     (w_nxt == S_ISSUE),
    .o_pending   (w_pending)
  );
  assign w_byte = r_state == S_COLLECT && i2c.out_valid;
  assign w_cnt  = (w_byte && r_cnt != 4'hF) ? r_cnt + 4'd1 : r_cnt;
  assign w_wr   = w_byte && r_cnt < 4'(NUM_BYTES);
  // the byte landing with in_ready's rise must reach the published values in the same step
  always_comb begin
    for (int k = 0; k < 3; k++) w_sh[k] = (w_wr && r_cnt == 4'(k)) ? i2c.out_data : r_shadow[k];
  end
  always_comb begin
    w_fsm = S_IDLE;
    case (r_state)
      S_IDLE:    w_fsm = (w_pending && i2c.in_ready) ? S_ISSUE : S_IDLE;
      S_ISSUE:   w_fsm = S_WAIT;
      S_WAIT:    w_fsm = i2c.in_ready ? S_WAIT : S_COLLECT;
      S_COLLECT: w_fsm = !i2c.in_ready ? S_COLLECT : (w_cnt == 4'(NUM_BYTES)) ? S_PUBLISH : S_ERROR;
      default:   w_fsm = S_IDLE;
    endcase
  end
  assign w_nxt = (w_to && (w_fsm == S_WAIT || w_fsm == S_COLLECT)) ? S_ERROR : w_fsm;
`ifdef RTC_POLL_WATCHDOG_EN
  logic [31:0] r_wd;
  assign w_to = (r_state == S_WAIT || r_state == S_COLLECT) && r_wd == 32'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) r_wd <= '0;
    else r_wd <= (w_nxt == S_ISSUE) ? '0 : (r_state == S_WAIT || r_state == S_COLLECT) ? r_wd + 32'd1 : r_wd;
  end
`else
  assign w_to = 1'b0;
`endif
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_shadow   <= '{default: '0};
      r_rd       <= 1'b0;
      busy       <= 1'b0;
      time_valid <= 1'b0;
      err        <= 1'b0;
      sec_bcd    <= '0;
      min_bcd    <= '0;
      hour_bcd   <= '0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= (r_state == S_ISSUE) ? '0 : w_cnt;
      r_shadow   <= w_sh;
      r_rd       <= w_nxt == S_ISSUE;
      busy       <= w_nxt != S_IDLE;
      time_valid <= w_nxt == S_PUBLISH;
      err        <= (w_nxt == S_ERROR) ? 1'b1 : (w_nxt == S_PUBLISH) ? 1'b0 : err;
      if (w_nxt == S_PUBLISH) begin
        sec_bcd <= w_sh[0] & SEC_MASK;
        if (NUM_BYTES > 1) min_bcd <= w_sh[1] & MIN_MASK;
        if (NUM_BYTES > 2) hour_bcd <= w_sh[2] & HOUR_MASK;
      end
    end
  end
endmodule

// File: tb/tb_rtc_poll_scheduler.sv
// tb_rtc_poll_scheduler: directed checks of polling, coalescing, error, masking, reset and watchdog.
module tb_rtc_poll_scheduler;
  localparam int PD = 400;
  localparam int TO = 100;
  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  logic force_req = 1'b0;
  logic [7:0] sec_bcd, min_bcd, hour_bcd;
  logic time_valid, err, busy;
  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int n_rd = 0;
  int n_tv = 0;
  int snap;
  rtc_poll_scheduler_if i2c();
  rtc_poll_scheduler #(
    .POLL_DIV(PD), .DEV_ADDR(7'h68), .NUM_BYTES(3)
`ifdef RTC_POLL_WATCHDOG_EN
    , .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .force_req(force_req), .i2c(i2c),
    .sec_bcd(sec_bcd), .min_bcd(min_bcd), .hour_bcd(hour_bcd),
    .time_valid(time_valid), .err(err), .busy(busy)
  );
  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys or negedge reset_n) cyc <= !reset_n ? 0 : cyc + 1;
  always @(negedge clk_sys) begin
    if (i2c.rd_address) n_rd <= n_rd + 1;
    if (time_valid) n_tv <= n_tv + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse();
    force_req = 1'b1;
    @(negedge clk_sys);
    force_req = 1'b0;
  endtask
  task automatic wait_rd(input string tag);
    int t = 0;
    while (i2c.rd_address !== 1'b1 && t < 1000) begin
      @(negedge clk_sys);
      t++;
    end
    chk(tag, i2c.rd_address, 1);
  endtask
  // I2C core model: called in the ISSUE cycle, returns in the cycle after in_ready rises
  task automatic serve(input logic [7:0] b0, b1, b2, b3, input int n, input bit coinc,
                       input int gap, input bit frc);
    logic [7:0] bs [4];
    bs = '{b0, b1, b2, b3};
    i2c.in_ready = 1'b0;
    repeat (2) @(negedge clk_sys);
    for (int i = 0; i < n; i++) begin
      i2c.out_data = bs[i];
      i2c.out_valid = 1'b1;
      if (frc && i == 0) force_req = 1'b1;
      if (coinc && i == n - 1) i2c.in_ready = 1'b1;
      @(negedge clk_sys);
      i2c.out_valid = 1'b0;
      force_req = 1'b0;
      if (!(coinc && i == n - 1)) repeat (gap) @(negedge clk_sys);
    end
    if (!coinc) begin
      i2c.in_ready = 1'b1;
      @(negedge clk_sys);
    end
  endtask
  initial begin
    i2c.in_ready = 1'b1;
    i2c.out_valid = 1'b0;
    i2c.out_data = 8'h00;
    repeat (3) @(negedge clk_sys);
    chk("rst_rd", i2c.rd_address, 0);
    chk("rst_wr", i2c.wr_address, 0);
    chk("rst_sec", sec_bcd, 0);
    chk("rst_min", min_bcd, 0);
    chk("rst_hour", hour_bcd, 0);
    chk("rst_tv", time_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_busy", busy, 0);
    chk("dev_addr", i2c.data_address, 7'h68);
    chk("byte_read", i2c.byte_read, 3);
    reset_n = 1'b1;
    while (cyc < PD + 1) @(negedge clk_sys);
    chk("rd_before_tick", i2c.rd_address, 0);
    @(negedge clk_sys);
    chk("rd_at_pd_plus2", i2c.rd_address, 1);
    chk("busy_issue", busy, 1);
    serve(8'h45, 8'h59, 8'h23, 8'h00, 3, 0, 1, 0);
    chk("t1_tv", time_valid, 1);
    chk("t1_sec", sec_bcd, 8'h45);
    chk("t1_min", min_bcd, 8'h59);
    chk("t1_hour", hour_bcd, 8'h23);
    chk("t1_err", err, 0);
    chk("t1_busy_pub", busy, 1);
    @(negedge clk_sys);
    chk("t1_tv_once", time_valid, 0);
    chk("t1_busy_idle", busy, 0);
    // short read: error, outputs held
    snap = n_tv;
    pulse();
    chk("frc_lat1", i2c.rd_address, 0);
    @(negedge clk_sys);
    chk("frc_lat2", i2c.rd_address, 1);
    serve(8'h11, 8'h22, 8'h00, 8'h00, 2, 0, 1, 0);
    chk("short_err", err, 1);
    chk("short_tv", time_valid, 0);
    chk("short_sec", sec_bcd, 8'h45);
    chk("short_min", min_bcd, 8'h59);
    chk("short_hour", hour_bcd, 8'h23);
    @(negedge clk_sys);
    chk("short_no_tv", n_tv - snap, 0);
    chk("short_err_sticky", err, 1);
    // good read clears err; hour masked
    pulse();
    wait_rd("rd_mask");
    serve(8'h12, 8'h34, 8'hE3, 8'h00, 3, 0, 1, 0);
    chk("mask_err_clr", err, 0);
    chk("mask_sec", sec_bcd, 8'h12);
    chk("mask_min", min_bcd, 8'h34);
    chk("mask_hour", hour_bcd, 8'h23);
    @(negedge clk_sys);
    // extra 4th byte
    pulse();
    wait_rd("rd_long");
    serve(8'h01, 8'h02, 8'h03, 8'h04, 4, 0, 1, 0);
    chk("long_err", err, 1);
    chk("long_tv", time_valid, 0);
    chk("long_sec", sec_bcd, 8'h12);
    chk("long_hour", hour_bcd, 8'h23);
    @(negedge clk_sys);
    // last byte coincident with in_ready rising; sec/min masks
    pulse();
    wait_rd("rd_coinc");
    serve(8'hD9, 8'hFF, 8'h12, 8'h00, 3, 1, 1, 0);
    chk("coinc_tv", time_valid, 1);
    chk("coinc_err", err, 0);
    chk("coinc_sec", sec_bcd, 8'h59);
    chk("coinc_min", min_bcd, 8'h7F);
    chk("coinc_hour", hour_bcd, 8'h12);
    // force during COLLECT plus tick at cycle 2*PD -> exactly one more transaction
    while (cyc < 2 * PD - 10) @(negedge clk_sys);
    pulse();
    wait_rd("rd_coal");
    serve(8'h21, 8'h22, 8'h03, 8'h00, 3, 0, 6, 1);
    chk("coal_tv", time_valid, 1);
    chk("coal_sec", sec_bcd, 8'h21);
    snap = n_rd;
    @(negedge clk_sys);
    chk("coal_idle_rd", i2c.rd_address, 0);
    @(negedge clk_sys);
    chk("coal_rerun_rd", i2c.rd_address, 1);
    serve(8'h30, 8'h31, 8'h13, 8'h00, 3, 0, 1, 0);
    chk("coal_sec2", sec_bcd, 8'h30);
    chk("coal_hour2", hour_bcd, 8'h13);
    repeat (50) @(negedge clk_sys);
    chk("coal_one_extra", n_rd - snap, 1);
    // asynchronous reset mid-COLLECT
    pulse();
    wait_rd("rd_rst");
    i2c.in_ready = 1'b0;
    repeat (2) @(negedge clk_sys);
    i2c.out_data = 8'h55;
    i2c.out_valid = 1'b1;
    @(negedge clk_sys);
    i2c.out_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_sec", sec_bcd, 0);
    chk("arst_min", min_bcd, 0);
    chk("arst_hour", hour_bcd, 0);
    chk("arst_busy", busy, 0);
    chk("arst_tv", time_valid, 0);
    chk("arst_err", err, 0);
    i2c.in_ready = 1'b1;
    @(negedge clk_sys);
    reset_n = 1'b1;
    snap = n_tv;
    repeat (30) @(negedge clk_sys);
    chk("arst_no_pub", n_tv - snap, 0);
    chk("arst_sec_hold", sec_bcd, 0);
    chk("arst_idle", busy, 0);
    // in_ready stuck low during a read
    pulse();
    wait_rd("rd_stuck");
    i2c.in_ready = 1'b0;
    repeat (TO / 2) @(negedge clk_sys);
    chk("stuck_busy_mid", busy, 1);
    repeat (TO / 2 + 10) @(negedge clk_sys);
`ifdef RTC_POLL_WATCHDOG_EN
    chk("wd_err", err, 1);
    chk("wd_idle", busy, 0);
`else
    chk("nowd_busy", busy, 1);
    chk("nowd_err", err, 0);
    i2c.in_ready = 1'b1;
    @(negedge clk_sys);
    chk("nowd_empty_err", err, 1);
    @(negedge clk_sys);
`endif
    // request with in_ready low in IDLE must wait
    i2c.in_ready = 1'b0;
    snap = n_rd;
    pulse();
    repeat (10) @(negedge clk_sys);
    chk("idle_wait", n_rd - snap, 0);
    i2c.in_ready = 1'b1;
    @(negedge clk_sys);
    chk("idle_go", i2c.rd_address, 1);
    serve(8'h07, 8'h08, 8'h09, 8'h00, 3, 0, 1, 0);
    chk("final_err_clr", err, 0);
    chk("final_sec", sec_bcd, 8'h07);
    chk("final_hour", hour_bcd, 8'h09);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
